// File: rtl/lm70_pkg.sv
// lm70_pkg: shared definitions for the LM70 SPI temperature reader.
//
// Contents:
//   lm70_state_e  - FSM state encoding (IDLE, SETUP, SHIFT, HOLD, GAP)
//   FRAME_BITS    - serial frame length from the sensor
//   RAW_BITS      - width of the 0.25 degC temperature field (frame[15:5])
//   INT_BITS      - width of the whole-degree temperature (frame[15:7])
//   FRAC_BITS     - fractional bits dropped between raw and integer form
//   STATUS_BITS   - pattern the sensor places in frame[4:0]
//   SCK_TOGGLES   - sck transitions in one frame (one rise + one fall per bit)
package lm70_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } lm70_state_e;

  localparam int FRAME_BITS  = 16;
  localparam int RAW_BITS    = 11;
  localparam int INT_BITS    = 9;
  localparam int FRAC_BITS   = 2;
  localparam int SCK_TOGGLES = 2 * FRAME_BITS;

  localparam logic [4:0] STATUS_BITS = 5'b11111;

endpackage

// File: rtl/lm70_sck_gen.sv
// lm70_sck_gen: SCK timebase for the LM70 reader.
//
// A HALF_DIV-cycle tick counter runs while i_en is high. Each tick ends one
// half-period of sck. When i_toggle_en is also high the tick flips sck, and
// o_rise marks the clk edge that drives sck from 0 to 1 (the sample edge).
// Dropping i_en clears the counter and parks sck low.
//
// Parameters:
//   HALF_DIV     sck half-period in clk cycles (>= 1)
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_en         run the tick counter (low = clear counter, sck low)
//   i_toggle_en  allow ticks to toggle sck
//   o_sck        serial clock, idles low
//   o_tick       end of the current half-period (combinational)
//   o_rise       this clk edge drives sck 0->1 (combinational)
module lm70_sck_gen
  import lm70_pkg::*;
#(
  parameter int HALF_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_toggle_en,
  output logic o_sck,
  output logic o_tick,
  output logic o_rise
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_sck;
  logic          w_tick;

  assign w_tick = i_en && (r_cnt == CW'(HALF_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick && i_toggle_en) begin
        r_sck <= ~r_sck;
      end
    end
  end

  assign o_sck  = r_sck;
  assign o_tick = w_tick;
  assign o_rise = w_tick && i_toggle_en && !r_sck;

endmodule

// File: rtl/lm70_spi_reader.sv
// lm70_spi_reader: SPI read master for the LM70 temperature sensor.
//
// One accepted start runs a complete 16-bit read: cs_n falls at the accept
// edge, sck stays low for one half-period (SETUP), then toggles 32 times
// (SHIFT, sio sampled on each rising edge, MSB first), stays low for one more
// half-period (HOLD) and cs_n rises together with the temperature update.
// cs_n is therefore low for exactly 34*HALF_DIV cycles. A GAP of GAP_CYCLES
// follows, during which busy stays high and start is ignored.
//
// Optional build macro: LM70_FRAME_CHECK_EN
//   Adds o_frame_err. A frame whose status bits [4:0] are not all ones is
//   flagged and leaves the temperature outputs untouched (temp_valid still
//   pulses). A good frame clears the flag.
//
// Parameters:
//   HALF_DIV      sck half-period in clk cycles (>= 1)
//   GAP_CYCLES    idle cycles after a frame before start is accepted (>= 0)
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset, aborts any frame
//   i_start       request one frame, sampled only in IDLE
//   i_temp_set    unsigned over-temperature setpoint, whole degC
//   i_sio         serial data from the LM70
//   o_cs_n        chip select, active low
//   o_sck         serial clock, idles low
//   o_busy        high from start acceptance until GAP completes
//   o_temp_raw    signed temperature, LSB = 0.25 degC
//   o_temp_int    signed temperature, whole degC
//   o_temp_valid  one-cycle pulse when the temperature outputs update
//   o_over_temp   temp_int >= temp_set, registered at the update edge
//   o_frame_err   (LM70_FRAME_CHECK_EN only) last frame had bad status bits
module lm70_spi_reader
  import lm70_pkg::*;
#(
  parameter int HALF_DIV   = 2,
  parameter int GAP_CYCLES = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [7:0]                 i_temp_set,
  input  logic                       i_sio,
  output logic                       o_cs_n,
  output logic                       o_sck,
  output logic                       o_busy,
  output logic signed [RAW_BITS-1:0] o_temp_raw,
  output logic signed [INT_BITS-1:0] o_temp_int,
  output logic                       o_temp_valid,
  output logic                       o_over_temp
`ifdef LM70_FRAME_CHECK_EN
  ,
  output logic                       o_frame_err
`endif
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_SETUP = SETUP;
  localparam logic [2:0] S_SHIFT = SHIFT;
  localparam logic [2:0] S_HOLD  = HOLD;
  localparam logic [2:0] S_GAP   = GAP;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // Signed compare against the setpoint zero-extended into the signed domain,
  // so any negative temperature is below every setpoint.
  function automatic logic over_cmp(input logic signed [INT_BITS-1:0] temp,
                                    input logic [7:0]                 set_pt);
    logic signed [INT_BITS-1:0] set_s;
    set_s = $signed({1'b0, set_pt});
    return temp >= set_s;
  endfunction

  logic [2:0]                 r_state;
  logic                       r_cs_n;
  logic                       r_busy;
  logic [4:0]                 r_edge_cnt;
  logic [GW-1:0]              r_gap_cnt;
  logic [FRAME_BITS-1:0]      r_frame;
  logic signed [RAW_BITS-1:0] r_temp_raw;
  logic signed [INT_BITS-1:0] r_temp_int;
  logic                       r_temp_valid;
  logic                       r_over_temp;

  logic                       w_en;
  logic                       w_toggle_en;
  logic                       w_tick;
  logic                       w_rise;
  logic signed [RAW_BITS-1:0] w_new_raw;
  logic signed [INT_BITS-1:0] w_new_int;
  logic                       w_new_over;

`ifdef LM70_FRAME_CHECK_EN
  logic r_frame_err;
  logic w_frame_ok;
  assign w_frame_ok = (r_frame[4:0] == STATUS_BITS);
`else
  logic w_unused_status;
  assign w_unused_status = ^r_frame[4:0];
`endif

  assign w_en        = (r_state == S_SETUP) || (r_state == S_SHIFT) ||
                       (r_state == S_HOLD);
  assign w_toggle_en = (r_state == S_SHIFT);

  lm70_sck_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_sck_gen (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (w_en),
    .i_toggle_en (w_toggle_en),
    .o_sck       (o_sck),
    .o_tick      (w_tick),
    .o_rise      (w_rise)
  );

  // Every frame rewrites all 16 bits before it is used, so the shift
  // register needs no reset; an aborted frame is simply never published.
  always_ff @(posedge i_clk) begin
    if (w_rise) begin
      r_frame <= {r_frame[FRAME_BITS-2:0], i_sio};
    end
  end

  assign w_new_raw  = r_frame[FRAME_BITS-1 -: RAW_BITS];
  assign w_new_int  = w_new_raw[RAW_BITS-1:FRAC_BITS];
  assign w_new_over = over_cmp(w_new_int, i_temp_set);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cs_n       <= 1'b1;
      r_busy       <= 1'b0;
      r_edge_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_temp_raw   <= '0;
      r_temp_int   <= '0;
      r_temp_valid <= 1'b0;
      r_over_temp  <= 1'b0;
`ifdef LM70_FRAME_CHECK_EN
      r_frame_err  <= 1'b0;
`endif
    end else begin
      r_temp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cs_n     <= 1'b0;
            r_busy     <= 1'b1;
            r_edge_cnt <= '0;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_tick) begin
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // The last toggle is the 16th falling edge; sck is back low.
          if (w_tick) begin
            if (r_edge_cnt == 5'(SCK_TOGGLES - 1)) begin
              r_state <= S_HOLD;
            end else begin
              r_edge_cnt <= r_edge_cnt + 5'd1;
            end
          end
        end
        S_HOLD: begin
          if (w_tick) begin
            r_cs_n       <= 1'b1;
            r_temp_valid <= 1'b1;
`ifdef LM70_FRAME_CHECK_EN
            if (w_frame_ok) begin
              r_temp_raw  <= w_new_raw;
              r_temp_int  <= w_new_int;
              r_over_temp <= w_new_over;
              r_frame_err <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
            end
`else
            r_temp_raw  <= w_new_raw;
            r_temp_int  <= w_new_int;
            r_over_temp <= w_new_over;
`endif
            // With no gap the next start is accepted one edge later.
            if (GAP_CYCLES == 0) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: begin
          r_cs_n  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cs_n       = r_cs_n;
  assign o_busy       = r_busy;
  assign o_temp_raw   = r_temp_raw;
  assign o_temp_int   = r_temp_int;
  assign o_temp_valid = r_temp_valid;
  assign o_over_temp  = r_over_temp;
`ifdef LM70_FRAME_CHECK_EN
  assign o_frame_err  = r_frame_err;
`endif

endmodule
